// File: rtl/io_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : io_bus_master
//  Description : Initiator for the byte-lane peripheral bus used by timer-class
//                I/O slaves. One CPU word request becomes bus cycles:
//                  - write: a single beat carrying the full word
//                  - read : four byte beats at the word's byte addresses. The
//                           bytes are assembled little-endian into rdata.
//  Build option: IOM_GAP_EN - when defined, an idle GAP cycle (cs_ high) is
//                inserted between consecutive read beats for slow slaves.
//  Ports       : clk, rst            clock / synchronous active-high reset
//                req, req_rw_        request strobe, 1 = read / 0 = write
//                req_addr, req_wdata word address and write data
//                busy, done, rdata   status, 1-cycle completion, read word
//                bus_cs_, bus_rw_    chip select (active low), 1 = read
//                bus_addr, bus_idata peripheral address / data to slave
//                bus_odata           data from slave, only [7:0] is used
//  Revision    : 1.0 - initial release
// ============================================================================
module io_bus_master #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              req_rw_,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              bus_cs_,
    output logic              bus_rw_,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_idata,
    input  logic [DATA_W-1:0] bus_odata
);

    localparam logic [1:0] C_LAST_BEAT = 2'(DATA_W / 8 - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD   = 3'd2,
        S_DONE = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    state_t              r_state;
    logic [1:0]          r_beat;
    logic [ADDR_W-3:0]   r_addr_hi;   // word part of the latched read address
    logic                r_busy;
    logic                r_done;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_cs_n;
    logic                r_rw_n;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [DATA_W-1:0]   r_idata;

    logic [1:0]          w_next_beat;
    // Slaves present their byte on the low lane; upper lanes are don't-care.
    logic                w_unused_odata_hi;

    assign w_next_beat       = r_beat + 2'd1;
    assign w_unused_odata_hi = ^bus_odata[DATA_W-1:8];

    // Every bus-facing output is a register so the bus sees glitch-free
    // values for the whole cycle of the state that owns them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_beat     <= 2'd0;
            r_addr_hi  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rdata    <= '0;
            r_cs_n     <= 1'b1;
            r_rw_n     <= 1'b1;
            r_bus_addr <= '0;
            r_idata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_cs_n  <= 1'b1;
                    r_rw_n  <= 1'b1;
                    r_idata <= '0;
                    if (req) begin
                        r_busy    <= 1'b1;
                        r_cs_n    <= 1'b0;
                        r_addr_hi <= req_addr[ADDR_W-1:2];
                        if (req_rw_) begin
                            r_state    <= S_RD;
                            r_beat     <= 2'd0;
                            r_rw_n     <= 1'b1;
                            r_bus_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                        end else begin
                            r_state    <= S_WR;
                            r_rw_n     <= 1'b0;
                            r_bus_addr <= req_addr;
                            r_idata    <= req_wdata;
                        end
                    end
                end

                S_WR: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                    r_cs_n  <= 1'b1;
                    r_rw_n  <= 1'b1;
                    r_idata <= '0;
                end

                S_RD: begin
                    r_rdata[8*r_beat +: 8] <= bus_odata[7:0];
                    if (r_beat == C_LAST_BEAT) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_cs_n  <= 1'b1;
                    end else begin
                        r_beat <= w_next_beat;
`ifdef IOM_GAP_EN
                        // Deselect for one cycle; the address of the beat
                        // just taken stays on the bus during the gap.
                        r_state <= S_GAP;
                        r_cs_n  <= 1'b1;
`else
                        r_bus_addr <= {r_addr_hi, w_next_beat};
`endif
                    end
                end

                S_GAP: begin
                    r_state    <= S_RD;
                    r_cs_n     <= 1'b0;
                    r_bus_addr <= {r_addr_hi, r_beat};
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_cs_n  <= 1'b1;
                    r_rw_n  <= 1'b1;
                    r_idata <= '0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign rdata     = r_rdata;
    assign bus_cs_   = r_cs_n;
    assign bus_rw_   = r_rw_n;
    assign bus_addr  = r_bus_addr;
    assign bus_idata = r_idata;

endmodule
`default_nettype wire

// File: tb/tb_io_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_bus_master
//  Description : Self-checking bench for io_bus_master. A byte-addressed slave
//                memory answers reads; expected bus activity per cycle and the
//                assembled read word come from the bus rules and the memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_bus_master;

    localparam int AW = 16;
    localparam int DW = 32;
`ifdef IOM_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          req_rw_;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          busy;
    logic          done;
    logic [DW-1:0] rdata;
    logic          bus_cs_;
    logic          bus_rw_;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_idata;
    logic [DW-1:0] bus_odata;

    logic [7:0]    mem [256];

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] model_rd;

    always #5 clk = ~clk;

    // Slave: byte on the low lane, junk on upper lanes that must be ignored.
    assign bus_odata = {8'hA5, 8'h5A, 8'hC3, mem[bus_addr[7:0]]};

    io_bus_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_rw_   (req_rw_),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .bus_cs_   (bus_cs_),
        .bus_rw_   (bus_rw_),
        .bus_addr  (bus_addr),
        .bus_idata (bus_idata),
        .bus_odata (bus_odata)
    );

    task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] word_at(input logic [15:0] a);
        logic [7:0] base;
        base = {a[7:2], 2'b00};
        return {mem[base + 8'd3], mem[base + 8'd2], mem[base + 8'd1], mem[base]};
    endfunction

    // One full transaction, checked cycle by cycle from the IDLE cycle that
    // accepts it up to and including its DONE cycle.
    task automatic run_txn(input logic rw, input logic [15:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input bit hold);
        int          len;
        int          bt;
        logic [15:0] last_a;
        logic [51:0] exp_v;
        @(negedge clk);
        check("idle", {bus_cs_, bus_rw_, busy, done, bus_idata}, {4'b1100, 32'h0});
        req = 1'b1; req_rw_ = rw; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        if (hold) begin
            // Request stays asserted but with different contents: must be ignored.
            req_addr = ~a; req_wdata = ~wd; req_rw_ = ~rw;
        end else begin
            req = 1'b0;
        end
        len    = rw ? (GAP ? 8 : 5) : 2;
        last_a = rw ? {a[15:2], 2'b11} : a;
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            if (c == len) begin
                exp_v = {4'b1111, last_a, 32'h0};
            end else if (!rw) begin
                exp_v = {4'b0010, a, wd};
            end else if (GAP && (c % 2 == 0)) begin
                bt    = (c - 2) / 2;
                exp_v = {4'b1110, a[15:2], 2'(bt), 32'h0};
            end else begin
                bt    = GAP ? (c - 1) / 2 : c - 1;
                exp_v = {4'b0110, a[15:2], 2'(bt), 32'h0};
            end
            check($sformatf("cyc%0d_%s", c, rw ? "rd" : "wr"),
                  {bus_cs_, bus_rw_, busy, done, bus_addr, bus_idata}, exp_v);
            if (c == len) check("rdata", rdata, exp_rd);
        end
    endtask

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rw;
        logic [15:0] a;
        logic [31:0] wd;

        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;

        vt[0] = '{1'b0, 16'h0004, 32'h0000_0001, 32'h0000_0000};
        vt[1] = '{1'b1, 16'h0006, 32'h0,         32'h4433_2211};
        vt[2] = '{1'b0, 16'h1234, 32'hDEAD_BEEF, 32'h4433_2211};
        vt[3] = '{1'b1, 16'h0010, 32'h0,         32'h4948_4B4A};
        vt[4] = '{1'b1, 16'h00FE, 32'h0,         32'hA5A4_A7A6};
        vt[5] = '{1'b1, 16'h1234, 32'h0,         32'h6D6C_6F6E};
        vt[6] = '{1'b0, 16'h0000, 32'hFFFF_FFFF, 32'h6D6C_6F6E};

        rst = 1'b1; req = 1'b0; req_rw_ = 1'b1; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", {bus_cs_, bus_rw_, busy, done, rdata, bus_idata, bus_addr},
              {4'b1100, 32'h0, 32'h0, 16'h0});
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 7; i++)
            run_txn(vt[i].rw, vt[i].addr, vt[i].wdata, vt[i].exp_rd, 1'b0);
        model_rd = 32'h6D6C_6F6E;

        // Randomized transactions against the memory model
        for (int n = 0; n < 20; n++) begin
            rw = 1'($urandom);
            a  = 16'($urandom);
            wd = $urandom;
            if (rw) begin
                for (int k = 0; k < 4; k++) mem[{a[7:2], 2'(k)}] = 8'($urandom);
                model_rd = word_at(a);
            end
            run_txn(rw, a, wd, model_rd, 1'b0);
        end

        // req held high throughout: each transaction runs exactly once
        model_rd = word_at(16'h0021);
        run_txn(1'b1, 16'h0021, 32'h0, model_rd, 1'b1);
        run_txn(1'b0, 16'h00A0, 32'h1234_5678, model_rd, 1'b1);
        model_rd = word_at(16'h0042);
        run_txn(1'b1, 16'h0042, 32'h0, model_rd, 1'b1);
        req = 1'b0;

        // Reset during read beat 2 aborts without done, then a fresh read
        mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
        @(negedge clk);
        req = 1'b1; req_rw_ = 1'b1; req_addr = 16'h0006;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (GAP ? 5 : 3) @(negedge clk);
        check("rst_beat2", {bus_cs_, bus_addr}, {1'b0, 16'h0006});
        rst = 1'b1;
        @(negedge clk);
        check("rst_abort", {bus_cs_, bus_rw_, busy, done, rdata, bus_idata, bus_addr},
              {4'b1100, 32'h0, 32'h0, 16'h0});
        rst = 1'b0;
        @(negedge clk);
        check("rst_nodone", {busy, done}, 2'b00);
        run_txn(1'b1, 16'h0004, 32'h0, 32'h4433_2211, 1'b0);

        @(negedge clk);
        check("final_idle", {bus_cs_, busy, done}, 3'b100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
